// File: rtl/axi_burst_rd_slave.sv
`timescale 1ns/1ps
// AXI4 read-only burst responder: turns one AR request into per-beat 64-bit
// memory reads and returns the beats through a 2-entry buffer under rready backpressure.
module axi_burst_rd_slave #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  input  logic [1:0]        arburst,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  output logic              arready,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  output logic              rlast,
  input  logic              rready,
  output logic              mem_ren,
  output logic [ADDR_W-4:0] mem_raddr,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        burst_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic              err_q;
  logic [8:0]        iss_cnt_q, iss_cnt_d;
  logic [8:0]        ret_cnt_q, ret_cnt_d;
  logic              infl_q, infl_last_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic [63:0]       fifo_data_q [2];
  logic [1:0]        fifo_resp_q [2];
  logic              fifo_last_q [2];

  logic ar_hs, req_err, pop, push, issue;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [1:0]        burst,
                                                  input logic [7:0]        len,
                                                  input logic [2:0]        size);
    logic [ADDR_W-1:0] step, mask;
    step = {{(ADDR_W-1){1'b0}}, 1'b1} << size;
    // Container is (len+1) beats; only the low bits inside it advance.
    mask = (({{(ADDR_W-8){1'b0}}, len} + 1'b1) << size) - 1'b1;
    case (burst)
      2'b01:   next_addr = addr + step;
      2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr;
    endcase
  endfunction

  assign arready = (state_q == S_IDLE);
  assign ar_hs   = arvalid & arready;
  assign req_err = (arburst == 2'b11) || (arsize > 3'd3) ||
                   ((arburst == 2'b10) &&
                    !((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15)));

  assign rvalid = (cnt_q != 2'd0);
  assign pop    = rvalid & rready;
  assign push   = infl_q;
  // Count the beat in flight against the buffer so its landing never overflows it.
  assign issue  = (state_q == S_BURST) && (iss_cnt_q != 9'd0) &&
                  (({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));

  assign mem_ren   = issue & ~err_q;
  assign mem_raddr = addr_q[ADDR_W-1:3];
  assign rdata     = rvalid ? fifo_data_q[rd_ptr_q] : 64'd0;
  assign rresp     = rvalid ? fifo_resp_q[rd_ptr_q] : 2'b00;
  assign rlast     = rvalid & fifo_last_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iss_cnt_d = iss_cnt_q;
    ret_cnt_d = ret_cnt_q;
    cnt_d     = cnt_q + 2'(push) - 2'(pop);
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          state_d   = S_BURST;
          addr_d    = araddr;
          iss_cnt_d = {1'b0, arlen} + 9'd1;
          ret_cnt_d = {1'b0, arlen} + 9'd1;
        end
      end
      S_BURST: begin
        if (issue) begin
          addr_d    = next_addr(addr_q, burst_q, len_q, size_q);
          iss_cnt_d = iss_cnt_q - 9'd1;
        end
        if (pop) begin
          ret_cnt_d = ret_cnt_q - 9'd1;
          if (ret_cnt_q == 9'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      burst_q     <= 2'b00;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      err_q       <= 1'b0;
      iss_cnt_q   <= 9'd0;
      ret_cnt_q   <= 9'd0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      iss_cnt_q   <= iss_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      cnt_q       <= cnt_d;
      infl_q      <= issue;
      infl_last_q <= issue && (iss_cnt_q == 9'd1);
      if (ar_hs) begin
        burst_q <= arburst;
        len_q   <= arlen;
        size_q  <= arsize;
        err_q   <= req_err;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Buffer payload needs no reset: it is only visible while rvalid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= err_q ? 64'd0 : mem_rdata;
      fifo_resp_q[wr_ptr_q] <= err_q ? 2'b10 : 2'b00;
      fifo_last_q[wr_ptr_q] <= infl_last_q;
    end
  end

endmodule

// File: tb/tb_axi_burst_rd_slave.sv
`timescale 1ns/1ps
// Bench for axi_burst_rd_slave: directed and randomized bursts compared against
// an arithmetic burst-address model and a synchronous memory model.
module tb_axi_burst_rd_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic [1:0]  arburst = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic        rready = 1'b0;
  logic        mem_ren;
  logic [28:0] mem_raddr;
  logic [63:0] mem_rdata = '0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axi_burst_rd_slave #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen), .arsize(arsize),
    .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] mem_word(input logic [28:0] w);
    logic [31:0] h;
    h = {3'b000, w} * 32'h9E3779B1;
    return {h, 3'b011, w};
  endfunction

  // Synchronous memory: data one cycle after mem_ren, junk otherwise.
  always @(posedge clk)
    mem_rdata <= mem_ren ? mem_word(mem_raddr) : {32'hBAD0BAD0, $urandom};

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic pick_rready(input int mode, input int cyc);
    case (mode)
      1:       return ($urandom_range(0, 3) != 0);
      2:       return !(cyc >= 4 && cyc <= 6);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_burst(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l,
                           input logic [2:0] s, input int mode, input string name);
    logic [31:0] exp_addr[$];
    logic [28:0] iss_addr[$];
    int          iss_cyc[$];
    logic [63:0] bd[$];
    logic [1:0]  br[$];
    logic        bl[$];
    int          bc[$];
    logic [63:0] cont, base, off, a64;
    logic [31:0] ea;
    logic [63:0] pd;
    logic [1:0]  pr;
    logic        pl, held, err, done;
    int          n, step, cyc, budget, exp_iss;

    n    = int'(l) + 1;
    step = 1 << s;
    err  = (b == 2'b11) || (s > 3'd3) ||
           (b == 2'b10 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
    a64  = {32'd0, a};
    for (int i = 0; i < n; i++) begin
      if (b == 2'b01) begin
        exp_addr.push_back(a + 32'(i * step));
      end else if (b == 2'b10 && !err) begin
        cont = 64'(n * step);
        base = a64 - (a64 % cont);
        off  = (a64 - base + 64'(i * step)) % cont;
        exp_addr.push_back(32'(base + off));
      end else begin
        exp_addr.push_back(a);
      end
    end

    @(negedge clk);
    araddr = a; arburst = b; arlen = l; arsize = s; arvalid = 1'b1;
    rready = pick_rready(mode, 0);
    #1;
    check({name, ":arready_c0"}, 80'(arready), 80'(1));
    cyc = 0; held = 1'b0; done = 1'b0; budget = 40 + 8 * n;
    pd = '0; pr = '0; pl = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      arvalid = 1'b0;
      rready  = pick_rready(mode, cyc);
      #1;
      if (mem_ren) begin
        iss_addr.push_back(mem_raddr);
        iss_cyc.push_back(cyc);
      end
      check({name, ":rlast_wo_rvalid"}, 80'(rlast & ~rvalid), 80'(0));
      check({name, ":arready_and_rvalid"}, 80'(arready & rvalid), 80'(0));
      if (held)
        check({name, ":hold"}, {11'd0, rvalid, rdata, rresp, rlast}, {11'd0, 1'b1, pd, pr, pl});
      if (rvalid && rready) begin
        bd.push_back(rdata); br.push_back(rresp); bl.push_back(rlast); bc.push_back(cyc);
        if (rlast) done = 1'b1;
      end
      check({name, ":occupancy"}, 80'((iss_addr.size() - bd.size()) <= 2), 80'(1));
      held = rvalid && !rready;
      pd = rdata; pr = rresp; pl = rlast;
    end
    check({name, ":completed"}, 80'(done), 80'(1));
    @(negedge clk);
    rready = 1'b0;
    #1;
    check({name, ":arready_after"}, 80'(arready), 80'(1));
    check({name, ":rvalid_after"}, 80'(rvalid), 80'(0));

    check({name, ":beat_count"}, 80'(bd.size()), 80'(n));
    for (int i = 0; i < n && i < bd.size(); i++) begin
      ea = exp_addr[i];
      check($sformatf("%s:data[%0d]", name, i), 80'(bd[i]), err ? 80'(0) : 80'(mem_word(ea[31:3])));
      check($sformatf("%s:resp[%0d]", name, i), 80'(br[i]), err ? 80'(2) : 80'(0));
      check($sformatf("%s:last[%0d]", name, i), 80'(bl[i]), 80'(i == n - 1));
    end
    exp_iss = err ? 0 : n;
    check({name, ":issue_count"}, 80'(iss_addr.size()), 80'(exp_iss));
    for (int i = 0; i < exp_iss && i < iss_addr.size(); i++) begin
      ea = exp_addr[i];
      check($sformatf("%s:raddr[%0d]", name, i), 80'(iss_addr[i]), 80'(ea[31:3]));
      if (mode == 0)
        check($sformatf("%s:issue_cyc[%0d]", name, i), 80'(iss_cyc[i]), 80'(1 + i));
    end
    if (mode == 0 && bc.size() == n) begin
      check({name, ":first_rvalid_cyc"}, 80'(bc[0]), 80'(3));
      check({name, ":last_cyc"}, 80'(bc[n-1]), 80'(n + 2));
    end
    if (mode == 2 && n >= 8 && bc.size() == n) begin
      check({name, ":beat1_cyc"}, 80'(bc[1]), 80'(7));
      check({name, ":last_cyc"}, 80'(bc[n-1]), 80'(13));
    end
  endtask

  initial begin
    logic [1:0] rb;
    logic [7:0] rl;
    logic [2:0] rs;

    #3;
    check("rst:arready", 80'(arready), 80'(1));
    check("rst:rvalid", 80'(rvalid), 80'(0));
    check("rst:rlast", 80'(rlast), 80'(0));
    check("rst:rresp", 80'(rresp), 80'(0));
    check("rst:rdata", 80'(rdata), 80'(0));
    check("rst:mem_ren", 80'(mem_ren), 80'(0));
    check("rst:mem_raddr", 80'(mem_raddr), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_burst(32'h80000040, 2'b01, 8'd7, 3'd3, 0, "incr");
    run_burst(32'h80000040, 2'b01, 8'd7, 3'd3, 2, "backpressure");
    run_burst(32'h00000038, 2'b10, 8'd3, 3'd3, 0, "wrap");
    run_burst(32'h00000100, 2'b00, 8'd3, 3'd3, 0, "fixed");
    run_burst(32'h00000104, 2'b01, 8'd2, 3'd2, 0, "narrow");
    run_burst(32'h00000000, 2'b11, 8'd2, 3'd3, 0, "err_rsv");
    run_burst(32'h00000040, 2'b10, 8'd2, 3'd3, 0, "err_wrap");
    run_burst(32'h00000008, 2'b01, 8'd1, 3'd5, 0, "err_size");
    run_burst(32'hFFFFFFF0, 2'b01, 8'd3, 3'd3, 0, "incr_addr_wrap");

    // Reset in the middle of beat 3 of an 8-beat burst.
    @(negedge clk);
    araddr = 32'h00001000; arburst = 2'b01; arlen = 8'd7; arsize = 3'd3;
    arvalid = 1'b1; rready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      arvalid = 1'b0;
    end
    #1;
    check("midrst:beat_valid_before", 80'(rvalid), 80'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midrst:rvalid", 80'(rvalid), 80'(0));
    check("midrst:arready", 80'(arready), 80'(1));
    check("midrst:mem_ren", 80'(mem_ren), 80'(0));
    check("midrst:rdata", 80'(rdata), 80'(0));
    check("midrst:mem_raddr", 80'(mem_raddr), 80'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("midrst:rvalid_after_release", 80'(rvalid), 80'(0));
    run_burst(32'h00002000, 2'b01, 8'd1, 3'd3, 0, "post_reset");

    for (int k = 0; k < 12; k++) begin
      rb = 2'($urandom_range(0, 3));
      if (rb == 2'b10 && $urandom_range(0, 4) != 0)
        rl = 8'((1 << $urandom_range(1, 4)) - 1);
      else
        rl = 8'($urandom_range(0, 15));
      rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      run_burst($urandom, rb, rl, rs, (k % 3 == 0) ? 0 : 1, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
